// File: rtl/spislave_pkg.sv
// Shared types and constants for the SPI target: state encoding, widths,
// mode codes and the frame-length mask helper.
package spislave_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned BITS_W = CNT_W - 1;
    localparam int unsigned DATA_W = 16;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Mask with len_m1+1 low bits set (0 -> 1 bit, 15 -> 16 bits).
    function automatic logic [DATA_W-1:0] frame_mask(input logic [BITS_W-1:0] len_m1);
        logic [DATA_W:0] m;
        m = ({{DATA_W{1'b0}}, 1'b1} << ({1'b0, len_m1} + 5'd1)) - {{DATA_W{1'b0}}, 1'b1};
        return m[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with registered level
// and single-cycle rise/fall pulses aligned to that level.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VAL}};
            level <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            level <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~level;
            fall  <= ~chain[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/spislave.sv
// SPI target: oversampled SCLK/CS/MOSI, all four CPOL/CPHA modes, 1-16 bit
// MSB-first frames, one TX holding register, back-to-back frames under one CS.
module spislave
    import spislave_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [BITS_W-1:0] bits,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_abort,
    output logic              busy,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clkin),
        .rst_n (rst_n),
        .din   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (clkin),
        .rst_n (rst_n),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s  = mosi_chain[SYNC_STAGES-1];
    assign busy    = ~cs_level;
    assign miso_oe = busy;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BITS_W-1:0] bits_lat;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              sampled;
    logic              done_pend;

    logic              sample_lead;
    logic              sclk_edge, lead_edge, trail_edge;
    logic              sample_edge, drive_edge;
    logic              frame_start;
    logic [DATA_W-1:0] start_word;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        sample_lead = 1'b1;
        case ({cpol, cpha})
            SPI_MODE0, SPI_MODE2: sample_lead = 1'b1;
            SPI_MODE1, SPI_MODE3: sample_lead = 1'b0;
            default:              sample_lead = 1'b1;
        endcase
        // Level after the edge differs from cpol exactly on a leading edge.
        sclk_edge   = sclk_rise | sclk_fall;
        lead_edge   = sclk_edge & (sclk_level ^ cpol);
        trail_edge  = sclk_edge & ~(sclk_level ^ cpol);
        sample_edge = sample_lead ? lead_edge : trail_edge;
        drive_edge  = sample_lead ? trail_edge : lead_edge;
        frame_start = ((state == ST_IDLE) && cs_fall) ||
                      ((state == ST_ACTIVE) && done_pend && !cs_rise);
        start_word  = tx_ready ? '0 : hold;
        shifted     = tx_sh << 1;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            bits_lat    <= '0;
            hold        <= '0;
            tx_sh       <= '0;
            rx_sh       <= '0;
            sampled     <= 1'b0;
            done_pend   <= 1'b0;
            tx_ready    <= 1'b1;
            tx_underrun <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
            miso        <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (done_pend) begin
                        rx_data  <= rx_sh & frame_mask(bits_lat);
                        rx_valid <= 1'b1;
                    end
                    if (cs_rise) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        miso      <= 1'b0;
                        sampled   <= 1'b0;
                        done_pend <= 1'b0;
                        if (!done_pend && sampled) begin
                            frame_abort <= 1'b1;
                        end
                    end else if (!done_pend) begin
                        if (sample_edge) begin
                            rx_sh   <= {rx_sh[DATA_W-2:0], mosi_s};
                            sampled <= 1'b1;
                            if (cnt == '0) begin
                                done_pend <= 1'b1;
                            end else begin
                                cnt <= cnt - 5'd1;
                            end
                        end
                        // Before the first sample of a frame a drive edge only
                        // re-presents the MSB; this absorbs the trailing edge
                        // that follows a back-to-back completion in CPHA=0.
                        if (drive_edge) begin
                            if (sampled) begin
                                tx_sh <= shifted;
                                miso  <= shifted[bits_lat];
                            end else begin
                                miso <= tx_sh[bits_lat];
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (frame_start) begin
                cnt         <= {1'b0, bits};
                bits_lat    <= bits;
                tx_sh       <= start_word;
                miso        <= start_word[bits];
                tx_underrun <= tx_ready;
                tx_ready    <= 1'b1;
                rx_sh       <= '0;
                sampled     <= 1'b0;
                done_pend   <= 1'b0;
            end

            if (tx_load && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spislave.sv
// Self-checking bench for spislave: a bench-driven SPI master plus a
// word-level model of the holding register and frame sequencing.
module tb_spislave;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpol, cpha;
    logic [3:0]  bits;
    logic [15:0] tx_data;
    logic        tx_load;
    logic        tx_ready, tx_underrun, rx_valid, frame_abort, busy;
    logic [15:0] rx_data;
    logic        sclk, mosi, cs_n, miso, miso_oe;

    always #5 clk = ~clk;

    spislave #(.SYNC_STAGES(2)) dut (
        .clkin       (clk),
        .rst_n       (rst_n),
        .cpol        (cpol),
        .cpha        (cpha),
        .bits        (bits),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_abort (frame_abort),
        .busy        (busy),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .miso        (miso),
        .miso_oe     (miso_oe)
    );

    int checks = 0;
    int errors = 0;

    // Pulse monitor
    int          rx_cnt = 0;
    int          ur_cnt = 0;
    int          ab_cnt = 0;
    logic [15:0] rx_log [0:255];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_valid === 1'b1) begin
                rx_log[8'(rx_cnt)] <= rx_data;
                rx_cnt <= rx_cnt + 1;
            end
            if (tx_underrun === 1'b1) ur_cnt <= ur_cnt + 1;
            if (frame_abort === 1'b1) ab_cnt <= ab_cnt + 1;
        end
    end

    // Reference model: holding register and the word each frame transmits
    logic        m_full = 1'b0;
    logic [15:0] m_hold = '0;
    int          m_ur = 0;
    logic [15:0] cur_tx = '0;

    function automatic logic [15:0] m_mask(input int nb);
        logic [31:0] m;
        m = (32'h1 << nb) - 32'h1;
        return m[15:0];
    endfunction

    function automatic logic [15:0] m_start();
        if (m_full) begin
            m_full = 1'b0;
            return m_hold;
        end
        m_ur = m_ur + 1;
        return 16'h0000;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic m_frame_done(input int nb, output logic [15:0] sent);
        sent   = cur_tx & m_mask(nb);
        cur_tx = m_start();
    endtask

    task automatic do_load(input logic [15:0] w);
        checks++;
        if (tx_ready !== !m_full) begin
            errors++;
            $display("FAIL tx_ready before load: got %b expected %b", tx_ready, !m_full);
        end
        tx_data = w;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = w;
        end
    endtask

    task automatic set_mode(input logic [1:0] md, input logic [3:0] b);
        cpol = md[1];
        cpha = md[0];
        bits = b;
        sclk = md[1];
        cyc(3);
    endtask

    task automatic cs_begin();
        cs_n   = 1'b0;
        cur_tx = m_start();
        cyc(6);
    endtask

    task automatic cs_end();
        cyc(6);
        cs_n = 1'b1;
        cyc(10);
    endtask

    // Clocks nclk bits (MSB first) of an nb-bit frame; mi collects miso.
    task automatic master_frame(input int nclk, input int nb, input logic [15:0] mo,
                                output logic [15:0] mi);
        mi = '0;
        for (int i = nb - 1; i >= nb - nclk; i--) begin
            if (!cpha) begin
                mosi = mo[i];
                cyc(H);
                mi = {mi[14:0], miso};
                sclk = ~sclk;
                cyc(H);
                sclk = ~sclk;
            end else begin
                sclk = ~sclk;
                mosi = mo[i];
                cyc(H);
                mi = {mi[14:0], miso};
                sclk = ~sclk;
                cyc(H);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(2);
        @(negedge clk);
        checks++;
        if ({miso, miso_oe, busy, tx_ready, tx_underrun, rx_valid, frame_abort, rx_data}
            !== {7'b0001000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {miso, miso_oe, busy, tx_ready, tx_underrun, rx_valid, frame_abort, rx_data},
                     {7'b0001000, 16'h0000});
        end
        rst_n = 1'b1;
        cyc(5);
        checks++;
        if ({miso_oe, busy, tx_ready, rx_data} !== {3'b001, 16'h0000}) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected %b",
                     {miso_oe, busy, tx_ready, rx_data}, {3'b001, 16'h0000});
        end
    endtask

    task automatic test_mode0();
        logic [15:0] mi, exp;
        int rb, ub, mu;
        set_mode(2'b00, 4'd7);
        do_load(16'h00A5);
        rb = rx_cnt; ub = ur_cnt; mu = m_ur;
        cs_begin();
        checks++;
        if (busy !== 1'b1 || miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL mode0_busy: got %b%b expected 11", busy, miso_oe);
        end
        master_frame(8, 8, 16'h003C, mi);
        m_frame_done(8, exp);
        cs_end();
        checks++;
        if (mi !== exp) begin
            errors++;
            $display("FAIL mode0_miso: got %h expected %h", mi, exp);
        end
        checks++;
        if (rx_cnt - rb !== 1) begin
            errors++;
            $display("FAIL mode0_rx_count: got %0d expected 1", rx_cnt - rb);
        end
        checks++;
        if (rx_log[8'(rb)] !== 16'h003C) begin
            errors++;
            $display("FAIL mode0_rx_data: got %h expected 003c", rx_log[8'(rb)]);
        end
        checks++;
        if (ur_cnt - ub !== m_ur - mu) begin
            errors++;
            $display("FAIL mode0_underruns: got %0d expected %0d", ur_cnt - ub, m_ur - mu);
        end
    endtask

    task automatic test_modes();
        logic [15:0] mi, exp;
        int rb;
        for (int md = 1; md < 4; md++) begin
            set_mode(2'(md), 4'd15);
            do_load(16'hBEEF);
            rb = rx_cnt;
            cs_begin();
            master_frame(16, 16, 16'h1234, mi);
            m_frame_done(16, exp);
            cs_end();
            checks++;
            if (mi !== exp) begin
                errors++;
                $display("FAIL mode%0d_miso: got %h expected %h", md, mi, exp);
            end
            checks++;
            if (rx_cnt - rb !== 1 || rx_log[8'(rb)] !== 16'h1234) begin
                errors++;
                $display("FAIL mode%0d_rx: got %0d words last %h expected 1 words 1234",
                         md, rx_cnt - rb, rx_log[8'(rb)]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] mi1, mi2, e1, e2;
        int rb, ub, mu;
        set_mode(2'b00, 4'd7);
        do_load(16'h0011);
        rb = rx_cnt; ub = ur_cnt; mu = m_ur;
        cs_begin();
        do_load(16'h0022);
        master_frame(8, 8, 16'h00C3, mi1);
        m_frame_done(8, e1);
        do_load(16'h0033);
        master_frame(8, 8, 16'h005A, mi2);
        m_frame_done(8, e2);
        cs_end();
        checks++;
        if (mi1 !== e1 || mi2 !== e2) begin
            errors++;
            $display("FAIL b2b_miso: got %h %h expected %h %h", mi1, mi2, e1, e2);
        end
        checks++;
        if (rx_cnt - rb !== 2 || rx_log[8'(rb)] !== 16'h00C3 || rx_log[8'(rb + 1)] !== 16'h005A) begin
            errors++;
            $display("FAIL b2b_rx: got %0d words %h %h expected 2 words 00c3 005a",
                     rx_cnt - rb, rx_log[8'(rb)], rx_log[8'(rb + 1)]);
        end
        checks++;
        if (ur_cnt - ub !== m_ur - mu) begin
            errors++;
            $display("FAIL b2b_underruns: got %0d expected %0d", ur_cnt - ub, m_ur - mu);
        end
    endtask

    task automatic test_underrun();
        logic [15:0] mi, exp, mo;
        int rb, ub, mu;
        set_mode(2'b00, 4'd7);
        mo = 16'($urandom_range(0, 255));
        rb = rx_cnt; ub = ur_cnt; mu = m_ur;
        cs_begin();
        checks++;
        if (ur_cnt - ub !== m_ur - mu) begin
            errors++;
            $display("FAIL underrun_at_cs: got %0d expected %0d", ur_cnt - ub, m_ur - mu);
        end
        master_frame(8, 8, mo, mi);
        m_frame_done(8, exp);
        cs_end();
        checks++;
        if (mi !== exp) begin
            errors++;
            $display("FAIL underrun_miso: got %h expected %h", mi, exp);
        end
        checks++;
        if (rx_cnt - rb !== 1 || rx_log[8'(rb)] !== mo) begin
            errors++;
            $display("FAIL underrun_rx: got %0d words %h expected 1 words %h",
                     rx_cnt - rb, rx_log[8'(rb)], mo);
        end
    endtask

    task automatic test_load_ignored();
        logic [15:0] mi, exp;
        set_mode(2'b10, 4'd7);
        do_load(16'h0069);
        do_load(16'h0096);
        cs_begin();
        master_frame(8, 8, 16'h0001, mi);
        m_frame_done(8, exp);
        cs_end();
        checks++;
        if (mi !== exp) begin
            errors++;
            $display("FAIL load_ignored_miso: got %h expected %h", mi, exp);
        end
    endtask

    task automatic test_abort();
        logic [15:0] mi, exp, held;
        int rb, ab;
        set_mode(2'b00, 4'd7);
        do_load(16'h005A);
        rb = rx_cnt; ab = ab_cnt; held = rx_data;
        cs_begin();
        master_frame(3, 8, 16'h00FF, mi);
        cyc(6);
        cs_n = 1'b1;
        cyc(4);
        @(negedge clk);
        checks++;
        if (miso_oe !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_oe: got %b%b expected 00", miso_oe, busy);
        end
        cyc(8);
        checks++;
        if (ab_cnt - ab !== 1 || rx_cnt - rb !== 0) begin
            errors++;
            $display("FAIL abort_pulses: got abort %0d rx %0d expected abort 1 rx 0",
                     ab_cnt - ab, rx_cnt - rb);
        end
        checks++;
        if (tx_ready !== !m_full || rx_data !== held) begin
            errors++;
            $display("FAIL abort_hold: got ready %b rx %h expected ready %b rx %h",
                     tx_ready, rx_data, !m_full, held);
        end
        do_load(16'h00E7);
        rb = rx_cnt;
        cs_begin();
        master_frame(8, 8, 16'h0081, mi);
        m_frame_done(8, exp);
        cs_end();
        checks++;
        if (mi !== exp || rx_cnt - rb !== 1 || rx_log[8'(rb)] !== 16'h0081) begin
            errors++;
            $display("FAIL after_abort_frame: got miso %h rx %0d/%h expected miso %h rx 1/0081",
                     mi, rx_cnt - rb, rx_log[8'(rb)], exp);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] mi, exp;
        int rb, ab;
        set_mode(2'b11, 4'd15);
        do_load(16'hC0DE);
        cs_begin();
        master_frame(5, 16, 16'hAAAA, mi);
        rb = rx_cnt; ab = ab_cnt;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({miso, miso_oe, busy, tx_ready, tx_underrun, rx_valid, frame_abort, rx_data}
            !== {7'b0001000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_midframe: got %b expected %b",
                     {miso, miso_oe, busy, tx_ready, tx_underrun, rx_valid, frame_abort, rx_data},
                     {7'b0001000, 16'h0000});
        end
        m_full = 1'b0;
        cs_n = 1'b1;
        sclk = cpol;
        mosi = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(8);
        checks++;
        if (ab_cnt - ab !== 0 || rx_cnt - rb !== 0) begin
            errors++;
            $display("FAIL reset_no_pulses: got abort %0d rx %0d expected 0 0",
                     ab_cnt - ab, rx_cnt - rb);
        end
        do_load(16'h7E57);
        cs_begin();
        master_frame(16, 16, 16'h4B1D, mi);
        m_frame_done(16, exp);
        cs_end();
        checks++;
        if (mi !== exp || rx_cnt - rb !== 1 || rx_log[8'(rb)] !== 16'h4B1D) begin
            errors++;
            $display("FAIL after_reset_frame: got miso %h rx %0d/%h expected miso %h rx 1/4b1d",
                     mi, rx_cnt - rb, rx_log[8'(rb)], exp);
        end
    endtask

    task automatic test_random();
        logic [15:0] mi, exp, mo;
        int nb, nf, rb, ub, mu;
        for (int it = 0; it < 10; it++) begin
            nb = int'($urandom_range(1, 16));
            nf = int'($urandom_range(1, 2));
            set_mode(2'($urandom_range(0, 3)), 4'(nb - 1));
            if ($urandom_range(0, 3) != 0) do_load(16'($urandom));
            rb = rx_cnt; ub = ur_cnt; mu = m_ur;
            cs_begin();
            for (int f = 0; f < nf; f++) begin
                if ($urandom_range(0, 1) != 0) do_load(16'($urandom));
                mo = 16'($urandom) & m_mask(nb);
                master_frame(nb, nb, mo, mi);
                m_frame_done(nb, exp);
                checks++;
                if (mi !== exp) begin
                    errors++;
                    $display("FAIL rand%0d_f%0d_miso: got %h expected %h", it, f, mi, exp);
                end
                checks++;
                if (rx_cnt - rb !== f + 1 || rx_log[8'(rb + f)] !== mo) begin
                    errors++;
                    $display("FAIL rand%0d_f%0d_rx: got %0d words %h expected %0d words %h",
                             it, f, rx_cnt - rb, rx_log[8'(rb + f)], f + 1, mo);
                end
            end
            cs_end();
            checks++;
            if (ur_cnt - ub !== m_ur - mu) begin
                errors++;
                $display("FAIL rand%0d_underruns: got %0d expected %0d", it, ur_cnt - ub, m_ur - mu);
            end
        end
    endtask

    initial begin
        cpol    = 1'b0;
        cpha    = 1'b0;
        bits    = 4'd7;
        tx_data = '0;
        tx_load = 1'b0;
        sclk    = 1'b0;
        mosi    = 1'b0;
        cs_n    = 1'b1;
        test_reset();
        test_mode0();
        test_modes();
        test_back_to_back();
        test_underrun();
        test_load_ignored();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
